// File: rtl/bitrev_reorder_buffer.sv
// -----------------------------------------------------------------------------
// bitrev_reorder_buffer
//
// Purpose:
//   Converts the bit-reversed sample stream coming out of an SDF FFT pipeline
//   into natural order. Two ping-pong banks of NFFT complex words are used:
//   the writer fills one bank at bit-reversed addresses while the reader
//   streams the other bank out at linear addresses. Each bank carries a full
//   flag that hands it from writer to reader and back.
//
// Parameters:
//   NFFT    frame length in samples (power of two, >= 4)
//   DATA_W  width of each real / imaginary component
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-low reset
//   in_valid    input sample present this cycle
//   in_re/im    input sample (bit-reversed order)
//   in_ready    writer is in FILL, so a sample can be accepted
//   out_valid   out_re/out_im/out_idx hold a valid sample
//   out_ready   downstream accepts the output sample this cycle
//   out_re/im   output sample (natural order)
//   out_idx     natural-order index of the current output sample
//   frame_done  pulse on the handshake of the sample with out_idx = NFFT-1
//   overflow    sticky: an input sample was dropped
// -----------------------------------------------------------------------------
module bitrev_reorder_buffer #(
    parameter int NFFT   = 128,
    parameter int DATA_W = 16,
    localparam int AW    = $clog2(NFFT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [AW-1:0]     out_idx,
    output logic              frame_done,
    output logic              overflow
);

    typedef enum logic {
        WR_FILL = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NFFT - 1);

    // Storage: two banks, read combinationally
    logic [DATA_W-1:0] memRe_q [2][NFFT];
    logic [DATA_W-1:0] memIm_q [2][NFFT];

    // Writer state
    wr_state_t     wrState_q, wrState_d;
    logic [AW-1:0] wrCnt_q,   wrCnt_d;
    logic          wrBank_q,  wrBank_d;

    // Reader state
    rd_state_t     rdState_q, rdState_d;
    logic [AW-1:0] rdCnt_q,   rdCnt_d;
    logic          rdBank_q,  rdBank_d;

    // Bank handshake flags
    logic [1:0]    full_q,    full_d;

    // Output register
    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outRe_q,    outRe_d;
    logic [DATA_W-1:0] outIm_q,    outIm_d;
    logic [AW-1:0]     outIdx_q,   outIdx_d;
    logic              overflow_q, overflow_d;

    // Per-cycle events
    logic          wrAccept;
    logic          wrLast;
    logic          rdLoad;
    logic          rdLast;
    logic [AW-1:0] wrAddr;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign in_ready   = (wrState_q == WR_FILL);
    assign out_valid  = outValid_q;
    assign out_re     = outRe_q;
    assign out_im     = outIm_q;
    assign out_idx    = outIdx_q;
    assign overflow   = overflow_q;
    assign frame_done = outValid_q && out_ready && (outIdx_q == LAST_IDX);

    assign wrAccept = in_valid && (wrState_q == WR_FILL);
    assign wrLast   = wrAccept && (wrCnt_q == LAST_IDX);
    assign wrAddr   = bitrev(wrCnt_q);
    assign rdLoad   = (rdState_q == RD_READ) && (!outValid_q || out_ready);
    assign rdLast   = rdLoad && (rdCnt_q == LAST_IDX);

    // Full flags: the reader only ever clears the bank it streams (which is
    // full) and the writer only sets the bank it fills (which is empty), so a
    // clear and a set landing on the same bank cannot happen. Different banks
    // may be cleared and set at the same edge and both take effect.
    always_comb begin
        full_d = full_q;
        if (rdLast) begin
            full_d[rdBank_q] = 1'b0;
        end
        if (wrLast) begin
            full_d[wrBank_q] = 1'b1;
        end
    end

    // Writer next state. On finishing a bank, the next bank is judged against
    // full_d so a bank released at this same edge is taken straight away.
    always_comb begin
        wrState_d = wrState_q;
        wrCnt_d   = wrCnt_q;
        wrBank_d  = wrBank_q;
        if (wrAccept) begin
            wrCnt_d = wrCnt_q + AW'(1);
        end
        unique case (wrState_q)
            WR_FILL: begin
                if (wrLast) begin
                    wrBank_d  = ~wrBank_q;
                    wrState_d = full_d[~wrBank_q] ? WR_WAIT : WR_FILL;
                end
            end
            WR_WAIT: begin
                if (!full_q[wrBank_q]) begin
                    wrState_d = WR_FILL;
                end
            end
            default: wrState_d = WR_FILL;
        endcase
    end

    // Reader next state. Looking at full_d lets the reader start on the same
    // edge the bank fills (one-cycle latency) and chain straight into the
    // other bank when it completes at the edge the current one drains.
    always_comb begin
        rdState_d = rdState_q;
        rdCnt_d   = rdCnt_q;
        rdBank_d  = rdBank_q;
        if (rdLoad) begin
            rdCnt_d = rdCnt_q + AW'(1);
        end
        unique case (rdState_q)
            RD_IDLE: begin
                if (full_d[rdBank_q]) begin
                    rdState_d = RD_READ;
                end
            end
            RD_READ: begin
                if (rdLast) begin
                    rdBank_d  = ~rdBank_q;
                    rdState_d = full_d[~rdBank_q] ? RD_READ : RD_IDLE;
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    // Output register: loads a new word whenever it is empty or being
    // consumed; otherwise holds, or empties on a handshake with nothing new.
    always_comb begin
        outValid_d = outValid_q;
        outRe_d    = outRe_q;
        outIm_d    = outIm_q;
        outIdx_d   = outIdx_q;
        if (rdLoad) begin
            outValid_d = 1'b1;
            outRe_d    = memRe_q[rdBank_q][rdCnt_q];
            outIm_d    = memIm_q[rdBank_q][rdCnt_q];
            outIdx_d   = rdCnt_q;
        end else if (outValid_q && out_ready) begin
            outValid_d = 1'b0;
        end
    end

    assign overflow_d = overflow_q || (in_valid && !in_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrState_q  <= WR_FILL;
            wrCnt_q    <= '0;
            wrBank_q   <= 1'b0;
            rdState_q  <= RD_IDLE;
            rdCnt_q    <= '0;
            rdBank_q   <= 1'b0;
            full_q     <= '0;
            outValid_q <= 1'b0;
            outRe_q    <= '0;
            outIm_q    <= '0;
            outIdx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrState_q  <= wrState_d;
            wrCnt_q    <= wrCnt_d;
            wrBank_q   <= wrBank_d;
            rdState_q  <= rdState_d;
            rdCnt_q    <= rdCnt_d;
            rdBank_q   <= rdBank_d;
            full_q     <= full_d;
            outValid_q <= outValid_d;
            outRe_q    <= outRe_d;
            outIm_q    <= outIm_d;
            outIdx_q   <= outIdx_d;
            overflow_q <= overflow_d;
        end
    end

    // Bank contents are not reset; stale data is never read because the
    // full flags are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst && wrAccept) begin
            memRe_q[wrBank_q][wrAddr] <= in_re;
            memIm_q[wrBank_q][wrAddr] <= in_im;
        end
    end

    noSameFlagSetClear: assert property (@(posedge clk) disable iff (!rst)
        !(wrLast && rdLast && (wrBank_q == rdBank_q)));

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_bitrev_reorder_buffer
//
// Purpose:
//   Self-checking bench for bitrev_reorder_buffer with NFFT=8. Stimulus feeds
//   frames in bit-reversed order and pushes the natural-order response into a
//   scoreboard queue; a monitor compares every presented output sample with
//   the queue head and pops it on each handshake.
// -----------------------------------------------------------------------------
module tb_bitrev_reorder_buffer;

    localparam int NFFT   = 8;
    localparam int DATA_W = 16;
    localparam int AW     = 3;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic [AW-1:0]     idx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [AW-1:0]     out_idx;
    logic              frame_done;
    logic              overflow;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   runLen     = 0;
    int   maxRun     = 0;

    // Bit-reversed arrival order for an 8-point frame
    int   brTab [NFFT] = '{0, 4, 2, 6, 1, 5, 3, 7};

    bitrev_reorder_buffer #(
        .NFFT   (NFFT),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one input sample; returns #1 after the edge that samples it
    task automatic applyStimulus(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One full frame; the natural-order result is queued as the last sample
    // is issued, before the DUT can present it.
    task automatic sendFrame(input logic [DATA_W-1:0] base);
        for (int k = 0; k < NFFT; k++) begin
            if (k == NFFT - 1) begin
                for (int i = 0; i < NFFT; i++) begin
                    expQ.push_back('{re: base + DATA_W'(i), im: ~(base + DATA_W'(i)), idx: AW'(i)});
                end
            end
            applyStimulus(base + DATA_W'(brTab[k]), ~(base + DATA_W'(brTab[k])));
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic doReset();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every presented sample must equal the queue head, which also
    // proves the output holds steady through stalls.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedOutput: got idx %0d re 0x%0h, expected no output", out_idx, out_re);
            end else begin
                checkOutput("outRe",  out_re,  expQ[0].re);
                checkOutput("outIm",  out_im,  expQ[0].im);
                checkOutput("outIdx", out_idx, expQ[0].idx);
                if (out_ready) begin
                    checkOutput("frameDone", frame_done, (expQ[0].idx == AW'(NFFT - 1)));
                    void'(expQ.pop_front());
                    runLen++;
                    if (runLen > maxRun) maxRun = runLen;
                end else begin
                    runLen = 0;
                end
            end
        end else begin
            runLen = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        doReset();

        // Reset state
        checkOutput("rstOutValid",  out_valid,  0);
        checkOutput("rstOverflow",  overflow,   0);
        checkOutput("rstOutIdx",    out_idx,    0);
        checkOutput("rstOutRe",     out_re,     0);
        checkOutput("rstFrameDone", frame_done, 0);
        checkOutput("rstInReady",   in_ready,   1);
        rst = 1'b1;
        idleCycles(2);

        // Single frame: latency and in-order stream
        maxRun = 0;
        sendFrame(16'h0000);
        checkOutput("latencyNotEarly", out_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("latencyRise", out_valid, 1);
        checkOutput("latencyIdx0", out_idx, 0);
        waitDrain("drainSingle");
        checkOutput("runSingle", maxRun, 8);

        // Three back-to-back frames, no bubble
        idleCycles(2);
        maxRun = 0;
        sendFrame(16'h0100);
        sendFrame(16'h0200);
        sendFrame(16'h0300);
        waitDrain("drainTriple");
        checkOutput("runTriple", maxRun, 24);

        // Full back-pressure: both banks fill, 17th sample is dropped
        idleCycles(2);
        out_ready = 1'b0;
        sendFrame(16'h1000);
        sendFrame(16'h2000);
        checkOutput("inReadyFell", in_ready, 0);
        checkOutput("noOverflowYet", overflow, 0);
        applyStimulus(16'hDEAD, 16'hBEEF);
        in_valid = 1'b0;
        checkOutput("overflowSet", overflow, 1);
        out_ready = 1'b1;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        checkOutput("inReadyStillLow", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("inReadyReturn", in_ready, 1);
        waitDrain("drainStall");

        // Random stalls during output
        idleCycles(2);
        out_ready = 1'b0;
        sendFrame(16'h3000);
        for (int c = 0; c < 100 && expQ.size() != 0; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        waitDrain("drainRandom");

        // Reset mid-frame discards the partial frame
        idleCycles(2);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(16'h4000 + DATA_W'(brTab[k]), 16'h4444);
        end
        doReset();
        rst = 1'b1;
        checkOutput("midRstOverflow", overflow,  0);
        checkOutput("midRstInReady",  in_ready,  1);
        checkOutput("midRstOutValid", out_valid, 0);
        sendFrame(16'h5000);
        waitDrain("drainFresh");
        checkOutput("freshOverflow", overflow, 0);

        idleCycles(2);
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
